fetch_prefetch: RTL and testbench

- Instruction prefetch stage directly upstream of the execute stage.
- Streams sequential 16-bit instruction words from the memory/icache port into a small queue.
- Serves execute's ifetch/pc requests, returning the instruction word with an idone pulse.
- On a pc discontinuity (branch, trap, reset vector) it discards the queue and any in-flight response, then refetches from the new pc.

---
 rtl/fetch_prefetch_if.sv | 33 +++
 rtl/fetch_prefetch.sv | 174 +++++++++++++++++
 tb/tb_fetch_prefetch.sv | 296 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_prefetch_if.sv
// Bundle of the execute-side fetch handshake and the memory fetch port.
//
// Handshake semantics:
//   execute side : ifetch is raised with pc and held (pc stable) until idone
//                  pulses for one cycle; ins/ifault are valid in that cycle.
//   memory side  : mem_req is raised with mem_addr and both stay stable until
//                  the cycle in which mem_ack is high; mem_rdata/mem_fault are
//                  valid only in that mem_ack cycle.
interface fetch_prefetch_if #(
   parameter int VA = 16
);
   logic [VA-2:0] pc;
   logic          ifetch;
   logic [15:0]   ins;
   logic          idone;
   logic          ifault;
   logic          iready;
   logic          mem_req;
   logic [VA-2:0] mem_addr;
   logic          mem_ack;
   logic [15:0]   mem_rdata;
   logic          mem_fault;

   modport slave (
      input  pc, ifetch, mem_ack, mem_rdata, mem_fault,
      output ins, idone, ifault, iready, mem_req, mem_addr
   );

   modport master (
      output pc, ifetch, mem_ack, mem_rdata, mem_fault,
      input  ins, idone, ifault, iready, mem_req, mem_addr
   );
endinterface

// File: rtl/fetch_prefetch.sv
// Instruction prefetch stage: streams sequential halfword instruction words
// from memory into a small queue and hands them to execute on request.
// A pc discontinuity flushes the queue and refetches from the new pc.
// Optional macro PREFETCH_BYPASS_EN: when the queue is empty and the word
// execute is waiting for arrives from memory, deliver it directly instead
// of pushing it (saves one cycle of miss latency).
module fetch_prefetch #(
   parameter int RV    = 16,
   parameter int VA    = RV,
   parameter int DEPTH = 4
) (
   input  logic                 clk,
   input  logic                 reset,
   fetch_prefetch_if.slave      bus,
   output logic                 dbg_state
);
   localparam int AW = VA - 1;
   localparam int IW = $clog2(DEPTH);
   localparam int PW = IW + 1;

   typedef enum logic [0:0] {IDLE = 1'b0, REQ = 1'b1} state_e;

   state_e        state_q, state_d;
   logic [AW-1:0] fpc_q, fpc_d;
   logic [AW-1:0] redir_q, redir_d;
   logic          drop_q, drop_d;
   logic          halt_q, halt_d;
   logic [15:0]   ins_q, ins_d;
   logic          idone_q, idone_d;
   logic          ifault_q, ifault_d;
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;

   logic [AW-1:0] q_addr_q  [DEPTH];
   logic [15:0]   q_data_q  [DEPTH];
   logic          q_fault_q [DEPTH];

   logic          push;
   logic          empty, full;
   logic [AW-1:0] head_addr;
   logic [15:0]   head_data;
   logic          head_fault;
   logic          req_ok, hit, redirect, bypass;

   function automatic logic is_full(input logic [PW-1:0] w, input logic [PW-1:0] r);
      return (w[IW] != r[IW]) && (w[IW-1:0] == r[IW-1:0]);
   endfunction

   assign empty      = (wr_ptr_q == rd_ptr_q);
   assign full       = is_full(wr_ptr_q, rd_ptr_q);
   assign head_addr  = q_addr_q[rd_ptr_q[IW-1:0]];
   assign head_data  = q_data_q[rd_ptr_q[IW-1:0]];
   assign head_fault = q_fault_q[rd_ptr_q[IW-1:0]];

   // Execute only looks at ifetch when no delivery happened last cycle.
   assign req_ok   = bus.ifetch && !idone_q;
   assign hit      = req_ok && !empty && (head_addr == bus.pc);
   assign redirect = req_ok && (empty ? (fpc_q != bus.pc) : (head_addr != bus.pc));
`ifdef PREFETCH_BYPASS_EN
   assign bypass   = req_ok && empty && (state_q == REQ) && bus.mem_ack && !drop_q
                     && (fpc_q == bus.pc);
`else
   assign bypass   = 1'b0;
`endif

   assign bus.ins      = ins_q;
   assign bus.idone    = idone_q;
   assign bus.ifault   = ifault_q;
   assign bus.iready   = hit;
   assign bus.mem_req  = (state_q == REQ);
   assign bus.mem_addr = fpc_q;
   assign dbg_state    = (state_q == REQ);

   // Next-state: delivery, fetch FSM, queue pointers, then redirect override.
   always_comb begin
      state_d  = state_q;
      fpc_d    = fpc_q;
      redir_d  = redir_q;
      drop_d   = drop_q;
      halt_d   = halt_q;
      ins_d    = ins_q;
      idone_d  = 1'b0;
      ifault_d = 1'b0;
      push     = 1'b0;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q + PW'(hit);

      if (hit) begin
         idone_d  = 1'b1;
         ifault_d = head_fault;
         ins_d    = head_fault ? 16'h0000 : head_data;
      end
      if (bypass) begin
         idone_d  = 1'b1;
         ifault_d = bus.mem_fault;
         ins_d    = bus.mem_fault ? 16'h0000 : bus.mem_rdata;
      end

      case (state_q)
         IDLE: begin
            // A queued or delivered fault stops prefetch until a redirect.
            if (!full && !halt_q) state_d = REQ;
         end
         REQ: begin
            if (bus.mem_ack) begin
               if (drop_q) begin
                  drop_d = 1'b0;
                  fpc_d  = redir_q;
               end else begin
                  fpc_d    = fpc_q + AW'(1);
                  push     = !bypass;
                  wr_ptr_d = wr_ptr_q + PW'(push);
                  if (bus.mem_fault) halt_d = 1'b1;
                  if (bus.mem_fault || is_full(wr_ptr_d, rd_ptr_d)) state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase

      // Redirect wins over any push; an ack in the same cycle is discarded.
      if (redirect) begin
         push     = 1'b0;
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         halt_d   = 1'b0;
         state_d  = REQ;
         if ((state_q == REQ) && !bus.mem_ack) begin
            drop_d  = 1'b1;
            redir_d = bus.pc;
            fpc_d   = fpc_q;
         end else begin
            drop_d  = 1'b0;
            fpc_d   = bus.pc;
         end
      end
   end

   // Control and output registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q  <= IDLE;
         fpc_q    <= '0;
         redir_q  <= '0;
         drop_q   <= 1'b0;
         halt_q   <= 1'b0;
         ins_q    <= '0;
         idone_q  <= 1'b0;
         ifault_q <= 1'b0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         state_q  <= state_d;
         fpc_q    <= fpc_d;
         redir_q  <= redir_d;
         drop_q   <= drop_d;
         halt_q   <= halt_d;
         ins_q    <= ins_d;
         idone_q  <= idone_d;
         ifault_q <= ifault_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   // Queue storage; emptiness lives in the pointers so no reset is needed.
   always_ff @(posedge clk) begin
      if (push) begin
         q_addr_q[wr_ptr_q[IW-1:0]]  <= fpc_q;
         q_data_q[wr_ptr_q[IW-1:0]]  <= bus.mem_rdata;
         q_fault_q[wr_ptr_q[IW-1:0]] <= bus.mem_fault;
      end
   end
endmodule

// File: tb/tb_fetch_prefetch.sv
// Bench for fetch_prefetch: table-driven fetch sequence plus hand-written
// corner sequences, with a scoreboard of expected {ifault, ins} deliveries.
`timescale 1ns/1ps
module tb_fetch_prefetch;
   localparam int VA = 16;
   localparam int AW = VA - 1;
`ifdef PREFETCH_BYPASS_EN
   localparam int MISS_LAT = 3;
`else
   localparam int MISS_LAT = 4;
`endif

   typedef struct {
      logic [AW-1:0] pc;
      logic [15:0]   ins;
      logic          fault;
   } vec_t;

   logic clk = 1'b0;
   logic reset = 1'b0;
   logic dbg_state;

   fetch_prefetch_if #(.VA(VA)) bus ();

   fetch_prefetch #(.RV(16), .VA(VA), .DEPTH(4)) dut (
      .clk       (clk),
      .reset     (reset),
      .bus       (bus),
      .dbg_state (dbg_state)
   );

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   // ---------------- bookkeeping ----------------
   int tests_run = 0;
   int tests_failed = 0;
   logic [16:0]   exp_q[$];
   logic [AW-1:0] ack_log[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] log_at(input int i);
      if (i < ack_log.size()) return {17'd0, ack_log[i]};
      return 32'hFFFF_FFFF;
   endfunction

   function automatic logic [15:0] mem_word(input logic [AW-1:0] a);
      return 16'h1000 + {1'b0, a};
   endfunction

   // ---------------- memory responder ----------------
   int            ack_delay = 1;
   bit            dead_next = 1'b0;
   bit            stray = 1'b0;
   bit            fault_en = 1'b0;
   logic [AW-1:0] fault_addr = '0;
   int            ack_cnt = 0;

   initial begin
      bus.mem_ack   = 1'b0;
      bus.mem_rdata = '0;
      bus.mem_fault = 1'b0;
      forever begin
         @(negedge clk);
         bus.mem_ack   = 1'b0;
         bus.mem_fault = 1'b0;
         if (stray) begin
            bus.mem_ack   = 1'b1;
            bus.mem_rdata = 16'hBEEF;
            stray         = 1'b0;
            ack_cnt       = 0;
         end else if (bus.mem_req) begin
            ack_cnt++;
            if (ack_cnt >= ack_delay) begin
               ack_cnt       = 0;
               bus.mem_ack   = 1'b1;
               bus.mem_rdata = dead_next ? 16'hDEAD : mem_word(bus.mem_addr);
               bus.mem_fault = fault_en && (bus.mem_addr == fault_addr);
               dead_next     = 1'b0;
               ack_log.push_back(bus.mem_addr);
            end
         end else begin
            ack_cnt = 0;
         end
      end
   end

   // ---------------- delivery monitor / scoreboard ----------------
   logic prev_idone = 1'b0;
   logic [16:0] exp_item;

   initial begin
      forever begin
         @(negedge clk);
         if (bus.idone) begin
            check("no_b2b_idone", {31'd0, prev_idone}, 32'd0);
            if (exp_q.size() == 0) begin
               tests_run++;
               tests_failed++;
               $display("FAIL unexpected_idone: got ins=%h ifault=%b with no delivery pending",
                        bus.ins, bus.ifault);
            end else begin
               exp_item = exp_q.pop_front();
               check("delivery", {15'd0, bus.ifault, bus.ins}, {15'd0, exp_item});
            end
         end
         prev_idone = bus.idone;
      end
   end

   // ---------------- driver tasks ----------------
   task automatic cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic apply_reset();
      reset      = 1'b0;
      bus.ifetch = 1'b0;
      bus.pc     = '0;
      cycles(3);
      reset = 1'b1;
   endtask

   task automatic do_fetch(input logic [AW-1:0] a, input logic [15:0] e_ins,
                           input logic e_f, output int lat);
      logic [16:0] tmp;
      exp_q.push_back({e_f, e_ins});
      bus.pc     = a;
      bus.ifetch = 1'b1;
      lat        = 0;
      do begin
         @(posedge clk);
         #1;
         lat++;
      end while (!bus.idone && lat < 200);
      if (!bus.idone) begin
         tests_run++;
         tests_failed++;
         $display("FAIL fetch_timeout: pc=%h no idone after %0d cycles, required one", a, lat);
         tmp = exp_q.pop_back();
      end
   endtask

   task automatic wait_req(input logic [AW-1:0] a);
      int n = 0;
      while (!(bus.mem_req && bus.mem_addr == a) && n < 100) begin
         cycles(1);
         n++;
      end
      check("wait_req_addr", {17'd0, bus.mem_addr}, {17'd0, a});
   endtask

   // ---------------- watchdog ----------------
   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   // ---------------- test sequence ----------------
   vec_t vecs[10];
   int   lat;

   initial begin
      vecs[0] = '{pc: 15'h0000, ins: 16'h1000, fault: 1'b0};
      vecs[1] = '{pc: 15'h0001, ins: 16'h1001, fault: 1'b0};
      vecs[2] = '{pc: 15'h0002, ins: 16'h1002, fault: 1'b0};
      vecs[3] = '{pc: 15'h0003, ins: 16'h1003, fault: 1'b0};
      vecs[4] = '{pc: 15'h0004, ins: 16'h1004, fault: 1'b0};
      vecs[5] = '{pc: 15'h0020, ins: 16'h1020, fault: 1'b0};
      vecs[6] = '{pc: 15'h0021, ins: 16'h1021, fault: 1'b0};
      vecs[7] = '{pc: 15'h0010, ins: 16'h1010, fault: 1'b0};
      vecs[8] = '{pc: 15'h7FFF, ins: 16'h8FFF, fault: 1'b0};
      vecs[9] = '{pc: 15'h0000, ins: 16'h1000, fault: 1'b0};

      bus.pc     = '0;
      bus.ifetch = 1'b0;

      // Reset state
      apply_reset();
      reset = 1'b0;
      cycles(1);
      check("rst_idone",   {31'd0, bus.idone},   32'd0);
      check("rst_ifault",  {31'd0, bus.ifault},  32'd0);
      check("rst_ins",     {16'd0, bus.ins},     32'd0);
      check("rst_mem_req", {31'd0, bus.mem_req}, 32'd0);
      check("rst_iready",  {31'd0, bus.iready},  32'd0);

      // 1: streaming, redirects, address wrap
      apply_reset();
      ack_log.delete();
      ack_delay = 1;
      for (int i = 0; i < 10; i++) do_fetch(vecs[i].pc, vecs[i].ins, vecs[i].fault, lat);
      bus.ifetch = 1'b0;
      for (int i = 0; i < 4; i++) check("t1_req_addr", log_at(i), i);
      cycles(4);

      // 2: fill with ifetch low, then one pop releases one request
      apply_reset();
      ack_log.delete();
      cycles(12);
      check("t2_fill_count", ack_log.size(), 32'd4);
      check("t2_last_addr",  log_at(3), 32'd3);
      check("t2_req_full",   {31'd0, bus.mem_req}, 32'd0);
      check("t2_state_idle", {31'd0, dbg_state},   32'd0);
      bus.pc     = '0;
      bus.ifetch = 1'b1;
      #1;
      check("t2_iready_hit", {31'd0, bus.iready}, 32'd1);
      do_fetch(15'h0000, 16'h1000, 1'b0, lat);
      check("t2_hit_latency", lat, 32'd1);
      bus.ifetch = 1'b0;
      cycles(10);
      check("t2_refill_count", ack_log.size(), 32'd5);
      check("t2_refill_addr",  log_at(4), 32'd4);

      // 3: redirect while the request to addr 5 is outstanding
      ack_delay = 1000;
      do_fetch(15'h0001, 16'h1001, 1'b0, lat);
      wait_req(15'h0005);
      ack_log.delete();
      bus.pc     = 15'h0040;
      bus.ifetch = 1'b1;
      cycles(2);
      dead_next = 1'b1;
      ack_delay = 1;
      do_fetch(15'h0040, 16'h1040, 1'b0, lat);
      bus.ifetch = 1'b0;
      check("t3_dropped_addr", log_at(0), 32'h5);
      check("t3_refetch_addr", log_at(1), 32'h40);

      // 4: fault on addr 2 stops prefetch until a redirect
      apply_reset();
      ack_log.delete();
      fault_en   = 1'b1;
      fault_addr = 15'h0002;
      do_fetch(15'h0000, 16'h1000, 1'b0, lat);
      do_fetch(15'h0001, 16'h1001, 1'b0, lat);
      do_fetch(15'h0002, 16'h0000, 1'b1, lat);
      bus.ifetch = 1'b0;
      cycles(10);
      check("t4_req_halted", {31'd0, bus.mem_req}, 32'd0);
      check("t4_req_count",  ack_log.size(), 32'd3);
      fault_en = 1'b0;
      do_fetch(15'h0008, 16'h1008, 1'b0, lat);
      bus.ifetch = 1'b0;
      check("t4_redirect_addr", log_at(3), 32'h8);

      // 5: reset during an outstanding request, stray acks ignored
      apply_reset();
      ack_delay  = 1000;
      bus.pc     = 15'h0007;
      bus.ifetch = 1'b1;
      wait_req(15'h0007);
      reset = 1'b0;
      cycles(1);
      check("t5_req_dropped", {31'd0, bus.mem_req}, 32'd0);
      check("t5_idone",       {31'd0, bus.idone},   32'd0);
      check("t5_iready",      {31'd0, bus.iready},  32'd0);
      check("t5_state_idle",  {31'd0, dbg_state},   32'd0);
      stray = 1'b1;
      cycles(1);
      ack_log.delete();
      reset     = 1'b1;
      stray     = 1'b1;
      ack_delay = 1;
      do_fetch(15'h0007, 16'h1007, 1'b0, lat);
      bus.ifetch = 1'b0;
      check("t5_first_addr", log_at(0), 32'h7);

      // 6: miss latency from an empty queue, ack delay 2
      apply_reset();
      cycles(10);
      ack_delay  = 2;
      bus.pc     = 15'h0010;
      bus.ifetch = 1'b1;
      #1;
      check("t6_iready_miss", {31'd0, bus.iready}, 32'd0);
      do_fetch(15'h0010, 16'h1010, 1'b0, lat);
      bus.ifetch = 1'b0;
      check("t6_miss_latency", lat, MISS_LAT);

      cycles(4);
      check("scoreboard_drained", exp_q.size(), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end
endmodule
